// File: rtl/fighter_health.sv
// Player/NPC health tracker; HP regeneration is compiled in with `define HEALTH_REGEN_EN.
// Hit to flag/HP latency is one frame edge; there is no backpressure, and an input is sampled every frame.

module fighter_health_unit #(
    parameter int HP_W          = 8,
    parameter int MAX_HP        = 100,
    parameter int DMG_W         = 4,
    parameter int INVULN_FRAMES = 30,
`ifdef HEALTH_REGEN_EN
    parameter int REGEN_PERIOD  = 60,
`endif
    parameter int DEAD_HOLD     = 120
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Restart,
    input  logic             game_l,
    input  logic             i_hit,
    input  logic [DMG_W-1:0] i_dmg,
    output logic [HP_W-1:0]  o_hp,
    output logic             o_invuln,
    output logic             o_dead
);
    localparam int CNT_MAX = (INVULN_FRAMES > DEAD_HOLD) ? INVULN_FRAMES : DEAD_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AW      = (HP_W > DMG_W) ? HP_W : DMG_W;

    typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_DEAD} state_t;

    state_t           r_state;
    logic [HP_W-1:0]  r_hp;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_lethal;
    logic [AW-1:0]    w_dmg_ext;
    logic             w_regen_tick;

    assign w_dmg_ext = AW'(i_dmg);
    assign w_accept  = game_l && i_hit && (i_dmg != '0) && (r_state == ST_ALIVE);
    // Compare at the wider width so a large damage value can never wrap HP.
    assign w_lethal  = w_dmg_ext >= AW'(r_hp);

`ifdef HEALTH_REGEN_EN
    localparam int RG_W = $clog2(REGEN_PERIOD + 1);
    logic [RG_W-1:0] r_regen_cnt;
    logic            w_regen_elig;

    // An accepted hit makes the frame ineligible, so a coincident tick is dropped.
    assign w_regen_elig = (r_state == ST_ALIVE) && game_l && !w_accept &&
                          (r_hp < HP_W'(MAX_HP));
    assign w_regen_tick = w_regen_elig && (r_regen_cnt == RG_W'(REGEN_PERIOD - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_regen_cnt <= '0;
        end else if (Restart || !w_regen_elig || w_regen_tick) begin
            r_regen_cnt <= '0;
        end else begin
            r_regen_cnt <= r_regen_cnt + 1'b1;
        end
    end
`else
    assign w_regen_tick = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_ALIVE;
            r_hp    <= HP_W'(MAX_HP);
            r_cnt   <= '0;
        end else if (Restart) begin
            r_state <= ST_ALIVE;
            r_hp    <= HP_W'(MAX_HP);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        if (w_lethal) begin
                            r_hp    <= '0;
                            r_state <= ST_DEAD;
                        end else begin
                            r_hp    <= r_hp - w_dmg_ext[HP_W-1:0];
                            r_state <= ST_INVULN;
                        end
                    end else if (w_regen_tick) begin
                        r_hp <= r_hp + 1'b1;
                    end
                end
                ST_INVULN: begin
                    if (r_cnt == CNT_W'(INVULN_FRAMES - 1)) begin
                        r_state <= ST_ALIVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (r_cnt == CNT_W'(DEAD_HOLD - 1)) begin
                        r_state <= ST_ALIVE;
                        r_hp    <= HP_W'(MAX_HP);
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ALIVE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_hp     = r_hp;
    assign o_invuln = (r_state == ST_INVULN);
    assign o_dead   = (r_state == ST_DEAD);
endmodule

// Two independent fighter trackers; simultaneous deaths are reported together and
// arbitrated downstream. One-edge latency, no backpressure.
module fighter_health #(
    parameter int HP_W          = 8,
    parameter int MAX_HP        = 100,
    parameter int DMG_W         = 4,
    parameter int INVULN_FRAMES = 30,
`ifdef HEALTH_REGEN_EN
    parameter int REGEN_PERIOD  = 60,
`endif
    parameter int DEAD_HOLD     = 120
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Restart,
    input  logic             game_l,
    input  logic             player_hit,
    input  logic [DMG_W-1:0] player_dmg,
    input  logic             npc_hit,
    input  logic [DMG_W-1:0] npc_dmg,
    output logic [HP_W-1:0]  player_hp,
    output logic [HP_W-1:0]  npc_hp,
    output logic             player_invuln,
    output logic             npc_invuln,
    output logic             Player_Dead,
    output logic             NPC_Dead
);
    fighter_health_unit #(
        .HP_W(HP_W), .MAX_HP(MAX_HP), .DMG_W(DMG_W), .INVULN_FRAMES(INVULN_FRAMES),
`ifdef HEALTH_REGEN_EN
        .REGEN_PERIOD(REGEN_PERIOD),
`endif
        .DEAD_HOLD(DEAD_HOLD)
    ) u_player (
        .Clk(Clk), .Reset(Reset), .Restart(Restart), .game_l(game_l),
        .i_hit(player_hit), .i_dmg(player_dmg),
        .o_hp(player_hp), .o_invuln(player_invuln), .o_dead(Player_Dead)
    );

    fighter_health_unit #(
        .HP_W(HP_W), .MAX_HP(MAX_HP), .DMG_W(DMG_W), .INVULN_FRAMES(INVULN_FRAMES),
`ifdef HEALTH_REGEN_EN
        .REGEN_PERIOD(REGEN_PERIOD),
`endif
        .DEAD_HOLD(DEAD_HOLD)
    ) u_npc (
        .Clk(Clk), .Reset(Reset), .Restart(Restart), .game_l(game_l),
        .i_hit(npc_hit), .i_dmg(npc_dmg),
        .o_hp(npc_hp), .o_invuln(npc_invuln), .o_dead(NPC_Dead)
    );
endmodule

// File: tb/tb_fighter_health.sv
// Scoreboard bench for fighter_health: stimulus queues the expected outputs of each frame,
// a monitor pops and compares them just after every clock edge.
module tb_fighter_health;
    logic       Clk = 1'b0;
    logic       Reset, Restart, game_l, player_hit, npc_hit;
    logic [3:0] player_dmg, npc_dmg;
    logic [7:0] player_hp, npc_hp;
    logic       player_invuln, npc_invuln, Player_Dead, NPC_Dead;

    always #5 Clk = ~Clk;

`ifdef HEALTH_REGEN_EN
    fighter_health #(.REGEN_PERIOD(4)) dut (
`else
    fighter_health dut (
`endif
        .Clk(Clk), .Reset(Reset), .Restart(Restart), .game_l(game_l),
        .player_hit(player_hit), .player_dmg(player_dmg),
        .npc_hit(npc_hit), .npc_dmg(npc_dmg),
        .player_hp(player_hp), .npc_hp(npc_hp),
        .player_invuln(player_invuln), .npc_invuln(npc_invuln),
        .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead)
    );

    typedef struct {
        logic [7:0] php;
        logic [7:0] nhp;
        logic       pinv;
        logic       ninv;
        logic       pd;
        logic       nd;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input exp_t x);
        n_checks++;
        if (player_hp !== x.php || npc_hp !== x.nhp || player_invuln !== x.pinv ||
            npc_invuln !== x.ninv || Player_Dead !== x.pd || NPC_Dead !== x.nd) begin
            n_errors++;
            $display("FAIL %s @%0t: got php=%0d nhp=%0d pinv=%b ninv=%b pdead=%b ndead=%b, want php=%0d nhp=%0d pinv=%b ninv=%b pdead=%b ndead=%b",
                     x.name, $time, player_hp, npc_hp, player_invuln, npc_invuln, Player_Dead, NPC_Dead,
                     x.php, x.nhp, x.pinv, x.ninv, x.pd, x.nd);
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) check(q.pop_front());
        end
    end

    task automatic set_defaults();
        e.php = 8'd100; e.nhp = 8'd100;
        e.pinv = 1'b0;  e.ninv = 1'b0;
        e.pd = 1'b0;    e.nd = 1'b0;
    endtask

    task automatic frame(input string name, input logic g, input logic ph, input logic [3:0] pdm,
                         input logic nh, input logic [3:0] ndm, input logic rs);
        @(negedge Clk);
        game_l = g; player_hit = ph; player_dmg = pdm;
        npc_hit = nh; npc_dmg = ndm; Restart = rs;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) frame(name, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    // Non-lethal hit followed by the full 30-frame window and the first frame back in ALIVE.
    task automatic hit(input string name, input logic ph, input logic [3:0] pdm,
                       input logic nh, input logic [3:0] ndm);
        if (ph) begin e.php = e.php - {4'd0, pdm}; e.pinv = 1'b1; end
        if (nh) begin e.nhp = e.nhp - {4'd0, ndm}; e.ninv = 1'b1; end
        frame(name, 1'b1, ph, pdm, nh, ndm, 1'b0);
        idle({name, "_win"}, 29);
        e.pinv = 1'b0; e.ninv = 1'b0;
        idle({name, "_end"}, 1);
    endtask

    initial begin
        Reset = 1'b1; Restart = 1'b0; game_l = 1'b0;
        player_hit = 1'b0; player_dmg = 4'd0; npc_hit = 1'b0; npc_dmg = 4'd0;
        set_defaults();
        e.name = "reset_state";
        #3 check(e);
        @(negedge Clk);
        Reset = 1'b0;
        idle("post_reset", 2);

`ifdef HEALTH_REGEN_EN
        hit("hit2", 1'b1, 4'd2, 1'b0, 4'd0);
        idle("regen_98", 3);
        e.php = 8'd99;
        idle("regen_99", 4);
        e.php = 8'd100;
        idle("regen_100", 6);
`else
        e.php = 8'd93; e.pinv = 1'b1;
        frame("hit7", 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 29; i++)
            frame((i == 9) ? "hit_in_window" : "invuln_win", 1'b1, (i == 9), 4'd5, 1'b0, 4'd0, 1'b0);
        e.pinv = 1'b0;
        frame("invuln_end", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

        frame("gated_hit", 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
        frame("zero_dmg", 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
        e.php = 8'd100;
        frame("restart", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 6; i++) hit("both15", 1'b1, 4'd15, 1'b1, 4'd15);
        hit("both5", 1'b1, 4'd5, 1'b1, 4'd5);
        e.nhp = 8'd0; e.nd = 1'b1;
        frame("npc_lethal", 1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
        frame("dead_hit_ignored", 1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
        idle("npc_dead_hold", 118);
        e.nhp = 8'd100; e.nd = 1'b0;
        idle("npc_revive", 2);

        e.php = 8'd100;
        frame("restart2", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) hit("both15b", 1'b1, 4'd15, 1'b1, 4'd15);
        hit("both7", 1'b1, 4'd7, 1'b1, 4'd7);
        e.php = 8'd0; e.nhp = 8'd0; e.pd = 1'b1; e.nd = 1'b1;
        frame("both_lethal", 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        idle("both_dead", 5);
        set_defaults();
        frame("restart_dead", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle("after_restart", 1);

        e.php = 8'd85; e.pinv = 1'b1;
        frame("hit15", 1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 29; i++)
            frame("inv_game_low", 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        e.pinv = 1'b0;
        frame("inv_game_low_end", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

        hit("to70", 1'b1, 4'd15, 1'b0, 4'd0);
        hit("to55", 1'b1, 4'd15, 1'b0, 4'd0);
        e.php = 8'd40; e.pinv = 1'b1;
        frame("to40", 1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
        idle("pre_async", 5);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        set_defaults();
        e.name = "async_reset";
        check(e);
        @(negedge Clk);
        Reset = 1'b0;
        idle("after_async", 3);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations still queued, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule
